banked_bram: RTL

- Parametrised successor to the fixed 3x512x8 banked wrapper: NUM_BANKS iCE40 block-RAM banks of BANK_DEPTH x DATA_W form one flat memory.
- Provides one write port and one read port on a single clock, with a registered bank-select read mux and out-of-range error flags.
- Write/read collision handling is selectable, and a zero-fill clear engine runs after reset or on request.
- Backs the CPU data/instruction memory; the core holds requests while busy is high.

---
 rtl/banked_bram_pkg.sv | 27 ++
 rtl/banked_bram_bank.sv | 31 +++
 rtl/banked_bram.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/banked_bram_pkg.sv
// Shared types and constants for the banked block-RAM memory: controller
// states, iCE40 SB_RAM read/write mode codes and a constant-safe clog2.
package bram_pkg;

    typedef enum logic {
        READY = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // SB_RAM40_4K READ_MODE/WRITE_MODE encodings
    localparam int SB_MODE_256X16 = 32'sd0;
    localparam int SB_MODE_512X8  = 32'sd1;

    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 32; i++) begin
            if ((32'sd1 << r) < value) begin
                r = r + 32'sd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/banked_bram_bank.sv
// One physical bank: stands in for an SB_RAM512x8 / SB_RAM256x16 primitive
// with a behavioural read-first synchronous RAM of the same geometry.
module bram_bank #(
    parameter int BANK_AW = 9,
    parameter int DATA_W  = 8
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [BANK_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic               re_i,
    input  logic [BANK_AW-1:0] raddr_i,
    output logic [DATA_W-1:0]  rdata_o
);

    logic [DATA_W-1:0] mem_q [2**BANK_AW];
    logic [DATA_W-1:0] rdata_q;

    // Storage write and registered read; a same-address read sees the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_bram.sv
// NUM_BANKS block-RAM banks presented as one flat memory with one write port,
// one 1-cycle read port, range errors, collision handling and a zero-fill engine.
module banked_bram
    import bram_pkg::*;
#(
    parameter int  NUM_BANKS      = 3,
    parameter int  BANK_AW        = 9,
    parameter int  DATA_W         = 8,
    parameter bit  WR_BYPASS      = 1'b1,
    parameter bit  CLEAR_ON_RESET = 1'b1,
    localparam int SEL_W          = (clog2(NUM_BANKS) < 1) ? 1 : clog2(NUM_BANKS),
    localparam int ADDR_W         = BANK_AW + SEL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              rd_err,
    output logic              wr_err,
    input  logic              clear_req,
    output logic              busy
);

    localparam logic [SEL_W:0]     NB_C       = (SEL_W + 1)'(NUM_BANKS);
    localparam logic [BANK_AW-1:0] CLR_LAST_C = BANK_AW'((2 ** BANK_AW) - 1);

    state_t             state_q;
    logic               busy_q;
    logic [BANK_AW-1:0] clr_cnt_q;

    logic [SEL_W-1:0]   rd_bank_s, wr_bank_s;
    logic               rd_in_s, wr_in_s, rd_acc_s, wr_acc_s, clearing_s;
    logic [NUM_BANKS-1:0] bank_we_s, bank_re_s;
    logic [BANK_AW-1:0] bank_waddr_s;
    logic [DATA_W-1:0]  bank_wdata_s;
    logic [DATA_W-1:0]  bank_rdata_s [NUM_BANKS];

    logic               rd_vld_q, rd_vld_d, rd_err_q, rd_err_d, wr_err_q, wr_err_d;
    logic [SEL_W-1:0]   rsel_q, rsel_d;
    logic               rin_q, rin_d, byp_q, byp_d;
    logic [DATA_W-1:0]  byp_data_q, byp_data_d;
    logic [DATA_W-1:0]  rd_data_s;

    // Controller: CLEAR walks every offset once, READY services requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : READY;
            busy_q    <= CLEAR_ON_RESET;
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                READY: begin
                    if (clear_req) begin
                        state_q   <= CLEAR;
                        busy_q    <= 1'b1;
                        clr_cnt_q <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == CLR_LAST_C) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + BANK_AW'(1);
                    end
                end
                default: begin
                    state_q <= READY;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Address decode, acceptance and per-bank enables; a clear writes all banks.
    always_comb begin
        rd_bank_s  = rd_addr[ADDR_W-1:BANK_AW];
        wr_bank_s  = wr_addr[ADDR_W-1:BANK_AW];
        rd_in_s    = {1'b0, rd_bank_s} < NB_C;
        wr_in_s    = {1'b0, wr_bank_s} < NB_C;
        clearing_s = (state_q == CLEAR);
        rd_acc_s   = (state_q == READY) && !reset && rd_valid;
        wr_acc_s   = (state_q == READY) && !reset && wr_valid;
        bank_we_s  = '0;
        bank_re_s  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_re_s[b] = rd_acc_s && rd_in_s && (rd_bank_s == SEL_W'(b));
            if (clearing_s) begin
                bank_we_s[b] = 1'b1;
            end else begin
                bank_we_s[b] = wr_acc_s && wr_in_s && (wr_bank_s == SEL_W'(b));
            end
        end
        if (clearing_s) begin
            bank_waddr_s = clr_cnt_q;
            bank_wdata_s = '0;
        end else begin
            bank_waddr_s = wr_addr[BANK_AW-1:0];
            bank_wdata_s = wr_data;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        bram_bank #(
            .BANK_AW (BANK_AW),
            .DATA_W  (DATA_W)
        ) u_bank (
            .clk_i   (clk),
            .we_i    (bank_we_s[g]),
            .waddr_i (bank_waddr_s),
            .wdata_i (bank_wdata_s),
            .re_i    (bank_re_s[g]),
            .raddr_i (rd_addr[BANK_AW-1:0]),
            .rdata_o (bank_rdata_s[g])
        );
    end

    // Response next-state: select, range and bypass only move on an accepted read.
    always_comb begin
        rd_vld_d   = rd_acc_s;
        rd_err_d   = rd_acc_s && !rd_in_s;
        wr_err_d   = wr_acc_s && !wr_in_s;
        rsel_d     = rsel_q;
        rin_d      = rin_q;
        byp_d      = byp_q;
        byp_data_d = byp_data_q;
        if (rd_acc_s) begin
            rsel_d     = rd_bank_s;
            rin_d      = rd_in_s;
            byp_d      = WR_BYPASS && wr_acc_s && wr_in_s && rd_in_s && (wr_addr == rd_addr);
            byp_data_d = wr_data;
        end else begin
            rsel_d = rsel_q;
        end
    end

    // Response registers travelling alongside the bank read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            rsel_q     <= '0;
            rin_q      <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rd_vld_q   <= rd_vld_d;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
            rsel_q     <= rsel_d;
            rin_q      <= rin_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    // Output mux driven only by registered select; out-of-range reads give zero.
    always_comb begin
        rd_data_s = '0;
        if (!rin_q) begin
            rd_data_s = '0;
        end else if (byp_q) begin
            rd_data_s = byp_data_q;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (rsel_q == SEL_W'(b)) begin
                    rd_data_s = bank_rdata_s[b];
                end
            end
        end
    end

    assign rd_data       = rd_data_s;
    assign rd_data_valid = rd_vld_q;
    assign rd_err        = rd_err_q;
    assign wr_err        = wr_err_q;
    assign busy          = busy_q;

endmodule
